// File: rtl/i2c_target_responder.sv
// i2c_target_responder: clocked I2C target. Oversamples SCL/SDA on ref_clk,
// detects START/STOP, answers one 7-bit address, captures written bytes and
// shifts out tx_data on reads. SDA is driven open-drain through sda_oe.
module i2c_target_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter logic [7:0] RX_RESET   = 8'h00
) (
  input  logic       ref_clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addr_match,
  output logic       txn_done,
  output logic       busy
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK = 3'd2;
  localparam logic [2:0] ST_WR_DATA  = 3'd3;
  localparam logic [2:0] ST_WR_ACK   = 3'd4;
  localparam logic [2:0] ST_RD_DATA  = 3'd5;
  localparam logic [2:0] ST_RD_ACK   = 3'd6;
  localparam logic [2:0] ST_IGNORE   = 3'd7;

  // Pin vector: bit 0 = SCL, bit 1 = SDA.
  logic [1:0] pin_vec;
  logic [1:0] pin_meta_reg;
  logic [1:0] pin_sync_reg;
  logic [1:0] pin_prev_reg;

  assign pin_vec = {sda_in, scl_in};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      // Two-flop synchronizer plus previous sample; during reset the chain is
      // preloaded with the pin level so no false edge appears on release.
      always_ff @(posedge ref_clk) begin
        if (!reset) begin
          pin_meta_reg[gi] <= pin_vec[gi];
          pin_sync_reg[gi] <= pin_vec[gi];
          pin_prev_reg[gi] <= pin_vec[gi];
        end else begin
          pin_meta_reg[gi] <= pin_vec[gi];
          pin_sync_reg[gi] <= pin_meta_reg[gi];
          pin_prev_reg[gi] <= pin_sync_reg[gi];
        end
      end
    end
  endgenerate

  logic scl_rise_next, scl_fall_next, start_next, stop_next;
  logic scl_rise_reg, scl_fall_reg, start_reg, stop_reg;
  logic sda_bit;

  assign scl_rise_next = pin_sync_reg[0] & ~pin_prev_reg[0];
  assign scl_fall_next = ~pin_sync_reg[0] & pin_prev_reg[0];
  assign start_next    = pin_sync_reg[0] & pin_prev_reg[0] & ~pin_sync_reg[1] & pin_prev_reg[1];
  assign stop_next     = pin_sync_reg[0] & pin_prev_reg[0] & pin_sync_reg[1] & ~pin_prev_reg[1];
  // SDA level as seen by the detector when the registered event fires.
  assign sda_bit       = pin_prev_reg[1];

  // Register bus events so each one is a single-cycle pulse for the FSM.
  always_ff @(posedge ref_clk) begin
    if (!reset) begin
      scl_rise_reg <= 1'b0;
      scl_fall_reg <= 1'b0;
      start_reg    <= 1'b0;
      stop_reg     <= 1'b0;
    end else begin
      scl_rise_reg <= scl_rise_next;
      scl_fall_reg <= scl_fall_next;
      start_reg    <= start_next;
      stop_reg     <= stop_next;
    end
  end

  logic [2:0] state_reg;
  logic [2:0] bit_cnt_reg;
  logic [7:0] shift_reg;
  logic [7:0] shift_in;
  logic       rw_reg;
  logic       ack_phase_reg;
  logic       sda_oe_reg;
  logic [7:0] rx_data_reg;
  logic       rx_valid_reg;
  logic       addr_match_reg;
  logic       txn_done_reg;
  logic       busy_reg;

  assign shift_in = {shift_reg[6:0], sda_bit};

  // Protocol FSM: START/STOP override bit processing in the same cycle.
  always_ff @(posedge ref_clk) begin
    rx_valid_reg <= 1'b0;
    txn_done_reg <= 1'b0;
    if (!reset) begin
      state_reg      <= ST_IDLE;
      bit_cnt_reg    <= 3'd0;
      shift_reg      <= 8'h00;
      rw_reg         <= 1'b0;
      ack_phase_reg  <= 1'b0;
      sda_oe_reg     <= 1'b0;
      rx_data_reg    <= RX_RESET;
      addr_match_reg <= 1'b0;
      busy_reg       <= 1'b0;
    end else if (start_reg) begin
      state_reg      <= ST_ADDR;
      bit_cnt_reg    <= 3'd0;
      ack_phase_reg  <= 1'b0;
      sda_oe_reg     <= 1'b0;
      addr_match_reg <= 1'b0;
      busy_reg       <= 1'b1;
    end else if (stop_reg) begin
      state_reg      <= ST_IDLE;
      bit_cnt_reg    <= 3'd0;
      ack_phase_reg  <= 1'b0;
      sda_oe_reg     <= 1'b0;
      busy_reg       <= 1'b0;
      txn_done_reg   <= addr_match_reg;
      addr_match_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_ADDR: begin
          if (scl_rise_reg) begin
            shift_reg   <= shift_in;
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              if (shift_in[7:1] == SLAVE_ADDR) begin
                state_reg      <= ST_ADDR_ACK;
                addr_match_reg <= 1'b1;
                rw_reg         <= shift_in[0];
                ack_phase_reg  <= 1'b0;
              end else begin
                state_reg <= ST_IGNORE;
              end
            end
          end
        end
        ST_ADDR_ACK: begin
          // First fall starts the ACK pulse, second fall ends the 9th clock.
          if (scl_fall_reg) begin
            if (!ack_phase_reg) begin
              sda_oe_reg    <= 1'b1;
              ack_phase_reg <= 1'b1;
            end else begin
              ack_phase_reg <= 1'b0;
              bit_cnt_reg   <= 3'd0;
              if (rw_reg) begin
                state_reg  <= ST_RD_DATA;
                shift_reg  <= tx_data;
                sda_oe_reg <= ~tx_data[7];
              end else begin
                state_reg  <= ST_WR_DATA;
                sda_oe_reg <= 1'b0;
              end
            end
          end
        end
        ST_WR_DATA: begin
          if (scl_rise_reg) begin
            shift_reg   <= shift_in;
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              rx_data_reg   <= shift_in;
              rx_valid_reg  <= 1'b1;
              state_reg     <= ST_WR_ACK;
              ack_phase_reg <= 1'b0;
            end
          end
        end
        ST_WR_ACK: begin
          if (scl_fall_reg) begin
            if (!ack_phase_reg) begin
              sda_oe_reg    <= 1'b1;
              ack_phase_reg <= 1'b1;
            end else begin
              sda_oe_reg    <= 1'b0;
              ack_phase_reg <= 1'b0;
              bit_cnt_reg   <= 3'd0;
              state_reg     <= ST_WR_DATA;
            end
          end
        end
        ST_RD_DATA: begin
          if (scl_fall_reg) begin
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              sda_oe_reg    <= 1'b0;
              ack_phase_reg <= 1'b0;
              state_reg     <= ST_RD_ACK;
            end else begin
              sda_oe_reg <= ~shift_reg[6];
              shift_reg  <= {shift_reg[6:0], 1'b0};
            end
          end
        end
        ST_RD_ACK: begin
          // Master ACK reloads the byte at the rise; its MSB goes out at the fall.
          if (scl_rise_reg && !ack_phase_reg) begin
            if (!sda_bit) begin
              shift_reg     <= tx_data;
              ack_phase_reg <= 1'b1;
            end else begin
              state_reg <= ST_IGNORE;
            end
          end else if (scl_fall_reg && ack_phase_reg) begin
            sda_oe_reg    <= ~shift_reg[7];
            bit_cnt_reg   <= 3'd0;
            ack_phase_reg <= 1'b0;
            state_reg     <= ST_RD_DATA;
          end
        end
        default: begin
          // IDLE and IGNORE wait for START/STOP and never drive SDA.
        end
      endcase
    end
  end

  assign sda_oe     = sda_oe_reg;
  assign rx_data    = rx_data_reg;
  assign rx_valid   = rx_valid_reg;
  assign addr_match = addr_match_reg;
  assign txn_done   = txn_done_reg;
  assign busy       = busy_reg;

endmodule
